egg_timer_bank: RTL and testbench
=================================

Name: egg_timer_bank

Overview:
- Parametrised, multi-channel successor of the single egg-timer datapath.
- Holds NUM_CH independent MM:SS BCD countdown timers that share one prescaler.
- Each timer can be loaded, started, paused, acknowledged and cleared.
- Presents the selected channel's four BCD digits to the existing seven-segment decoders, plus per-channel running, expired and flashing status for the LED bank.

Parameters:
- NUM_CH, 4, number of independent timer channels (1..16).
- CH_W, 2, width of channel select; must satisfy 2**CH_W >= NUM_CH.
- TICK_DIV, 50000000, clk cycles per one-second tick (>= 2).
- FLASH_EN, 1, when 1 expired channels flash; when 0 the flash output holds solid high while expired.

Ports:
- clk  input  1  system clock (50 MHz on board)
- reset_n  input  1  asynchronous, active-low reset
- ch_sel  input  CH_W  channel addressed by commands and by the digit outputs
- load_val  input  8  BCD pair from switches: [7:4] tens, [3:0] ones
- load_sec  input  1  single-cycle pulse: write load_val to the seconds field of ch_sel
- load_min  input  1  single-cycle pulse: write load_val to the minutes field of ch_sel
- start_stop  input  1  single-cycle pulse: start, pause, resume or acknowledge ch_sel
- clear  input  1  single-cycle pulse: clear ch_sel
- digit0..digit3  output  4 each  selected channel's digits: sec ones, sec tens, min ones, min tens
- running  output  NUM_CH  channel in RUN
- expired  output  NUM_CH  channel in EXPIRED
- flash  output  NUM_CH  expired AND flash phase (or expired when FLASH_EN=0)
- tick  output  1  one-cycle pulse at each prescaler rollover

Behaviour:
- Reset (async assert, sync release):
  - All channels go to IDLE with value 00:00 and preset 00:00.
  - Prescaler = 0, flash phase = 0.
  - All outputs are 0; digits show 0000.
- Prescaler:
  - Free-runs 0..TICK_DIV-1 from reset release.
  - tick is high in the cycle the count equals TICK_DIV-1.
  - The prescaler is shared, so the first decrement after a start lands 1..TICK_DIV cycles later.
- Flash phase toggles on every tick.
- Per-channel states: IDLE, RUN, PAUSE, EXPIRED.
- Load (load_sec/load_min), accepted in IDLE or PAUSE only; ignored in RUN and EXPIRED:
  - The field is registered on the next edge.
  - The value is copied into the preset as well.
  - Sanitising: any BCD digit > 9 clamps to 9; seconds tens > 5 clamps to 5.
- start_stop transitions:
  - IDLE -> RUN if value != 00:00; otherwise ignored.
  - RUN -> PAUSE.
  - PAUSE -> RUN if value != 00:00.
  - EXPIRED -> IDLE, reloading value from the preset (recall).
- Decrement, RUN channels only, on tick:
  - Seconds ones decrement, borrowing through seconds tens (0 -> 5), minutes ones (0 -> 9) and minutes tens.
  - When the value reaches 00:00 on a tick, the state becomes EXPIRED on the same edge.
  - The value holds at 00:00 in EXPIRED; there is no wrap-around.
- clear: any state -> IDLE; value and preset both become 00:00.
- Simultaneous commands in one cycle, priority clear > load_min > load_sec > start_stop; lower-priority commands that cycle are dropped.
- A command in the same cycle as tick:
  - The command applies; the tick does not decrement that channel that cycle.
  - Non-addressed channels decrement normally.
- Commands with ch_sel >= NUM_CH are ignored; digit outputs read 0000 for such an address.
- digit0..3 are a combinational mux of ch_sel. They have zero-cycle latency from ch_sel and one-cycle latency from a command.
- Status outputs are registered state decodes.
- A reset asserted mid-count aborts all channels immediately.

Test Plan (TICK_DIV=4 in simulation):
- Reset, then load_min=0x01 and load_sec=0x03 on ch0, then start_stop -> digits 0103. On successive ticks: 0102, 0101, 0100, 0059 (borrow). running[0]=1.
- ch1 loaded 00:02 and started -> after 2 ticks expired[1]=1, running[1]=0, value 0000. flash[1] toggles each tick. start_stop -> IDLE, digits 0002 (preset recall).
- Load 0xAF on seconds -> stored 59; load 0x7C on minutes -> stored 79. start_stop on 00:00 in IDLE -> state stays IDLE.
- Start ch0 at 00:10, pause after 3 ticks -> value 0007 frozen over 5 ticks. Resume -> decrements again. Meanwhile ch2 runs independently.
- clear and start_stop pulsed together on a running channel -> IDLE, 0000, preset 0000. load_sec during RUN -> ignored.
- Assert reset_n low mid-count -> all outputs 0 asynchronously, before the next clk edge. ch_sel=NUM_CH (when 2**CH_W > NUM_CH) -> digits 0000 and commands ignored.

Source files
------------

// File: rtl/egg_timer_bank.sv
// Bank of NUM_CH independent MM:SS BCD countdown timers sharing one one-second prescaler.
// Commands are single-cycle pulses addressed by ch_sel; digits show the addressed channel.
module egg_timer_bank #(
    parameter int NUM_CH   = 4,
    parameter int CH_W     = 2,
    parameter int TICK_DIV = 50000000,
    parameter int FLASH_EN = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CH_W-1:0]     ch_sel,
    input  logic [7:0]          load_val,
    input  logic                load_sec,
    input  logic                load_min,
    input  logic                start_stop,
    input  logic                clear,
    output logic [3:0]          digit0,
    output logic [3:0]          digit1,
    output logic [3:0]          digit2,
    output logic [3:0]          digit3,
    output logic [NUM_CH-1:0]   running,
    output logic [NUM_CH-1:0]   expired,
    output logic [NUM_CH-1:0]   flash,
    output logic                tick,
    output logic [2*NUM_CH-1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } ch_state_t;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0]     presc_q;
    logic              phase_q;
    ch_state_t         state_q  [NUM_CH];
    ch_state_t         state_d  [NUM_CH];
    logic [15:0]       val_q    [NUM_CH];
    logic [15:0]       val_d    [NUM_CH];
    logic [15:0]       preset_q [NUM_CH];
    logic [15:0]       preset_d [NUM_CH];
    logic [NUM_CH-1:0] hit;
    logic              any_cmd;
    logic [7:0]        sec_field;
    logic [7:0]        min_field;
    logic [15:0]       shown;

    function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // One-second BCD borrow chain; 00:00 is held rather than wrapped.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] so, st, mo, mt;
        {mt, mo, st, so} = v;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    if (mt != 4'd0) mt = mt - 4'd1;
                    else {mt, mo, st, so} = 16'h0000;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    assign tick      = (presc_q == PRESC_MAX);
    assign any_cmd   = clear | load_min | load_sec | start_stop;
    assign sec_field = {clamp(load_val[7:4], 4'd5), clamp(load_val[3:0], 4'd9)};
    assign min_field = {clamp(load_val[7:4], 4'd9), clamp(load_val[3:0], 4'd9)};

    // Addresses at or above NUM_CH match no channel, so they are ignored and display 0000.
    always_comb begin
        hit   = '0;
        shown = 16'h0000;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = (ch_sel == CH_W'(i));
            if (hit[i]) shown = val_q[i];
        end
    end

    assign {digit3, digit2, digit1, digit0} = shown;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            phase_q <= 1'b0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) phase_q <= ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= IDLE;
                val_q[i]    <= 16'h0000;
                preset_q[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= state_d[i];
                val_q[i]    <= val_d[i];
                preset_q[i] <= preset_d[i];
            end
        end
    end

    // An addressed command takes the channel's whole cycle, so a coincident tick skips it.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]  = state_q[i];
            val_d[i]    = val_q[i];
            preset_d[i] = preset_q[i];
            if (hit[i] && any_cmd) begin
                if (clear) begin
                    state_d[i]  = IDLE;
                    val_d[i]    = 16'h0000;
                    preset_d[i] = 16'h0000;
                end else if (load_min) begin
                    if (state_q[i] == IDLE || state_q[i] == PAUSE) begin
                        val_d[i][15:8]    = min_field;
                        preset_d[i][15:8] = min_field;
                    end
                end else if (load_sec) begin
                    if (state_q[i] == IDLE || state_q[i] == PAUSE) begin
                        val_d[i][7:0]    = sec_field;
                        preset_d[i][7:0] = sec_field;
                    end
                end else begin
                    case (state_q[i])
                        IDLE:    if (val_q[i] != 16'h0000) state_d[i] = RUN;
                        RUN:     state_d[i] = PAUSE;
                        PAUSE:   if (val_q[i] != 16'h0000) state_d[i] = RUN;
                        EXPIRED: begin
                            state_d[i] = IDLE;
                            val_d[i]   = preset_q[i];
                        end
                        default: state_d[i] = IDLE;
                    endcase
                end
            end else if (tick && state_q[i] == RUN) begin
                val_d[i] = bcd_dec(val_q[i]);
                if (val_d[i] == 16'h0000) state_d[i] = EXPIRED;
            end
        end
    end

    always_comb begin
        running   = '0;
        expired   = '0;
        flash     = '0;
        state_dbg = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            running[i]           = (state_q[i] == RUN);
            expired[i]           = (state_q[i] == EXPIRED);
            flash[i]             = expired[i] & ((FLASH_EN != 0) ? phase_q : 1'b1);
            state_dbg[2*i +: 2]  = state_q[i];
        end
    end

endmodule

// File: tb/tb_egg_timer_bank.sv
// Bench for egg_timer_bank: a seconds-count reference model feeds an expected queue that a
// free-running monitor drains one entry per clock, plus directed constant checks.
module tb_egg_timer_bank;

    localparam int NUM_CH   = 3;
    localparam int CH_W     = 2;
    localparam int TICK_DIV = 4;
    localparam int W        = 16 + 3 * NUM_CH + 1;

    localparam logic [3:0] C_NONE = 4'b0000;
    localparam logic [3:0] C_SS   = 4'b0001;
    localparam logic [3:0] C_LS   = 4'b0010;
    localparam logic [3:0] C_LM   = 4'b0100;
    localparam logic [3:0] C_CLR  = 4'b1000;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_EXP  = 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [CH_W-1:0]   ch_sel = '0;
    logic [7:0]        load_val = '0;
    logic              load_sec = 1'b0;
    logic              load_min = 1'b0;
    logic              start_stop = 1'b0;
    logic              clear = 1'b0;
    logic [3:0]        digit0, digit1, digit2, digit3;
    logic [NUM_CH-1:0] running, expired, flash;
    logic              tick;
    logic [2*NUM_CH-1:0] state_dbg;

    logic [W-1:0] exp_q[$];
    int tests = 0;
    int failed = 0;

    int m_st[NUM_CH];
    int m_min[NUM_CH];
    int m_sec[NUM_CH];
    int p_min[NUM_CH];
    int p_sec[NUM_CH];
    int m_p;
    bit m_phase;

    egg_timer_bank #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .TICK_DIV(TICK_DIV), .FLASH_EN(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ch_sel(ch_sel), .load_val(load_val),
        .load_sec(load_sec), .load_min(load_min), .start_stop(start_stop), .clear(clear),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .running(running), .expired(expired), .flash(flash), .tick(tick),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [W-1:0] observed();
        return {digit3, digit2, digit1, digit0, running, expired, flash, tick};
    endfunction

    function automatic int mn(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_st[c] = M_IDLE; m_min[c] = 0; m_sec[c] = 0; p_min[c] = 0; p_sec[c] = 0;
        end
        m_p = 0;
        m_phase = 1'b0;
    endtask

    // Advance the reference by one clock edge with the given command applied.
    task automatic model_step(input int cs, input logic [3:0] cmd, input logic [7:0] lv);
        bit tk;
        int t;
        tk = (m_p == TICK_DIV - 1);
        for (int c = 0; c < NUM_CH; c++) begin
            if (cs == c && cmd != C_NONE) begin
                if (cmd[3]) begin
                    m_st[c] = M_IDLE; m_min[c] = 0; m_sec[c] = 0; p_min[c] = 0; p_sec[c] = 0;
                end else if (cmd[2]) begin
                    if (m_st[c] == M_IDLE || m_st[c] == M_PAUSE) begin
                        m_min[c] = mn(int'(lv[7:4]), 9) * 10 + mn(int'(lv[3:0]), 9);
                        p_min[c] = m_min[c];
                    end
                end else if (cmd[1]) begin
                    if (m_st[c] == M_IDLE || m_st[c] == M_PAUSE) begin
                        m_sec[c] = mn(int'(lv[7:4]), 5) * 10 + mn(int'(lv[3:0]), 9);
                        p_sec[c] = m_sec[c];
                    end
                end else begin
                    t = m_min[c] * 60 + m_sec[c];
                    if (m_st[c] == M_IDLE && t != 0) m_st[c] = M_RUN;
                    else if (m_st[c] == M_RUN) m_st[c] = M_PAUSE;
                    else if (m_st[c] == M_PAUSE && t != 0) m_st[c] = M_RUN;
                    else if (m_st[c] == M_EXP) begin
                        m_st[c] = M_IDLE; m_min[c] = p_min[c]; m_sec[c] = p_sec[c];
                    end
                end
            end else if (tk && m_st[c] == M_RUN) begin
                t = m_min[c] * 60 + m_sec[c] - 1;
                m_min[c] = t / 60;
                m_sec[c] = t % 60;
                if (t == 0) m_st[c] = M_EXP;
            end
        end
        if (tk) m_phase = ~m_phase;
        m_p = (m_p + 1) % TICK_DIV;
    endtask

    function automatic logic [W-1:0] model_view(input int cs);
        logic [15:0] d;
        logic [NUM_CH-1:0] r, e, f;
        d = 16'h0000;
        if (cs < NUM_CH)
            d = {4'(m_min[cs] / 10), 4'(m_min[cs] % 10), 4'(m_sec[cs] / 10), 4'(m_sec[cs] % 10)};
        for (int c = 0; c < NUM_CH; c++) begin
            r[c] = (m_st[c] == M_RUN);
            e[c] = (m_st[c] == M_EXP);
            f[c] = e[c] & m_phase;
        end
        return {d, r, e, f, (m_p == TICK_DIV - 1)};
    endfunction

    // driver tasks
    task automatic drive(input int cs, input logic [3:0] cmd, input logic [7:0] lv);
        ch_sel     = CH_W'(cs);
        load_val   = lv;
        clear      = cmd[3];
        load_min   = cmd[2];
        load_sec   = cmd[1];
        start_stop = cmd[0];
        model_step(cs, cmd, lv);
        exp_q.push_back(model_view(cs));
    endtask

    task automatic cycle(input int cs, input logic [3:0] cmd, input logic [7:0] lv);
        @(negedge clk);
        drive(cs, cmd, lv);
    endtask

    task automatic idle(input int cs, input int n);
        for (int k = 0; k < n; k++) cycle(cs, C_NONE, 8'h00);
    endtask

    task automatic check_const(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #3;
    endtask

    // scoreboard monitor
    initial begin
        logic [W-1:0] want;
        logic [W-1:0] got;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = observed();
                tests++;
                if (got !== want) begin
                    failed++;
                    $display("FAIL scoreboard ch_sel=%0d got=%h want=%h at %0t", ch_sel, got, want, $time);
                end
            end
        end
    end

    initial begin
        int cs, r;
        logic [3:0] cmd;
        logic [7:0] lv;

        model_reset();
        repeat (3) @(negedge clk);
        check_const("reset_outputs", observed(), '0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(0, C_NONE, 8'h00);

        // ch0 01:03 counting down through a minute borrow
        cycle(0, C_LM, 8'h01);
        cycle(0, C_LS, 8'h03);
        cycle(0, C_SS, 8'h00);
        after_edge();
        check_const("start_digits", W'({digit3, digit2, digit1, digit0, running[0]}), W'({16'h0103, 1'b1}));
        idle(0, 20);

        // ch1 expires at 00:02, flashes, then recalls its preset
        cycle(1, C_LS, 8'h02);
        cycle(1, C_SS, 8'h00);
        idle(1, 14);
        cycle(1, C_SS, 8'h00);
        after_edge();
        check_const("recall_digits", W'({digit3, digit2, digit1, digit0, expired[1]}), W'({16'h0002, 1'b0}));
        idle(1, 2);

        // sanitising and start on zero
        cycle(2, C_LS, 8'hAF);
        cycle(2, C_LM, 8'h7C);
        after_edge();
        check_const("sanitise", W'({digit3, digit2, digit1, digit0}), W'(16'h7959));
        cycle(2, C_CLR, 8'h00);
        cycle(2, C_SS, 8'h00);
        idle(2, 3);

        // pause / resume with ch2 running alongside
        cycle(0, C_CLR, 8'h00);
        cycle(0, C_LS, 8'h10);
        cycle(0, C_SS, 8'h00);
        idle(0, 12);
        cycle(0, C_SS, 8'h00);
        cycle(2, C_LS, 8'h05);
        cycle(2, C_SS, 8'h00);
        idle(0, 20);
        cycle(0, C_SS, 8'h00);
        idle(2, 12);

        // clear beats start_stop; loads ignored while running; unmapped address
        cycle(0, C_CLR | C_SS, 8'h00);
        cycle(2, C_LS, 8'h30);
        cycle(2, C_SS, 8'h00);
        cycle(2, C_LS, 8'h45);
        idle(2, 4);
        cycle(3, C_LS, 8'h12);
        cycle(3, C_SS, 8'h00);
        idle(3, 4);

        // random traffic
        for (int k = 0; k < 1500; k++) begin
            cs = $urandom_range(0, 3);
            r  = $urandom_range(0, 99);
            if (r < 80) cmd = C_NONE;
            else if (r < 88) cmd = C_SS;
            else if (r < 92) cmd = C_LS;
            else if (r < 96) cmd = C_LM;
            else cmd = 4'($urandom_range(1, 15));
            lv = 8'($urandom_range(0, 255));
            if (cmd == C_LM && $urandom_range(0, 3) != 0) lv = 8'h00;
            cycle(cs, cmd, lv);
        end

        // reset mid-count must clear outputs before the next edge
        cycle(0, C_CLR, 8'h00);
        cycle(0, C_LM, 8'h05);
        cycle(0, C_SS, 8'h00);
        idle(0, 6);
        after_edge();
        check_const("running_before_reset", W'(running[0]), W'(1'b1));
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_const("async_reset", observed(), '0);
        model_reset();
        clear = 1'b0; load_min = 1'b0; load_sec = 1'b0; start_stop = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        drive(0, C_NONE, 8'h00);
        idle(0, 8);

        repeat (3) after_edge();
        check_const("queue_drained", W'(exp_q.size()), W'(0));
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
